// File: rtl/mem_port_arbiter_pkg.sv
// Shared load/store type codes, arbiter state/owner encodings and the
// alignment rule used by both the arbiter and the load/store path.
package mem_port_arbiter_pkg;

    localparam int LS_SEL_WIDTH = 2;

    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE          = 3'b000;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF          = 3'b001;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_WORD          = 3'b010;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_BYTE_UNSIGNED = 3'b100;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LOAD_HALF_UNSIGNED = 3'b101;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_BYTE         = 3'b000;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_HALF         = 3'b001;
    localparam logic [LS_SEL_WIDTH:0] LS_TYPE_STORE_WORD         = 3'b010;

    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_STATE_IDLE      = 2'd0,
        ARB_STATE_ISSUE     = 2'd1,
        ARB_STATE_WAIT_RESP = 2'd2,
        ARB_STATE_RESPOND   = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWNER_IF = 1'b0,
        ARB_OWNER_DM = 1'b1
    } arb_owner_e;

    // The low LS_SEL_WIDTH bits of the type code carry the access size.
    function automatic logic is_misaligned(input logic [LS_SEL_WIDTH:0] ls_type,
                                           input logic [1:0] addr_lsb);
        logic fault;
        case (ls_type[LS_SEL_WIDTH-1:0])
            2'b10, 2'b11: fault = (addr_lsb != 2'b00);
            2'b01:        fault = addr_lsb[0];
            default:      fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_fairness.sv
// Winner select for the shared memory port: data wins contention until it has
// taken MAX_DATA_STREAK contended grants in a row, then fetch is forced once.
module mem_arbiter_fairness
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_WIDTH    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_valid,
    input  logic       dm_valid,
    input  logic       grant,
    output arb_owner_e select
);

    localparam logic [STREAK_WIDTH-1:0] STREAK_LIMIT = STREAK_WIDTH'(MAX_DATA_STREAK);
    localparam logic [STREAK_WIDTH-1:0] STREAK_SAT   = '1;

    logic [STREAK_WIDTH-1:0] streak_q, streak_d;
    logic                    force_fetch;

    always_comb begin
        force_fetch = (MAX_DATA_STREAK != 0) && if_valid && (streak_q == STREAK_LIMIT);
        select      = (dm_valid && !force_fetch) ? ARB_OWNER_DM : ARB_OWNER_IF;
        streak_d    = streak_q;
        if (grant) begin
            if (select == ARB_OWNER_IF) begin
                streak_d = '0;
            end else if (if_valid && (streak_q != STREAK_SAT)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between instruction fetch and load/store,
// one transaction at a time; misaligned requests are answered locally.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_WIDTH    = 3
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_N,
    input  logic                    i_If_Req_Valid,
    input  logic [XLEN-1:0]         i_If_Addr,
    output logic                    o_If_Req_Ready,
    output logic                    o_If_Resp_Valid,
    output logic [XLEN-1:0]         o_If_Resp_Data,
    output logic                    o_If_Resp_Error,
    input  logic                    i_Dm_Req_Valid,
    input  logic                    i_Dm_Write_Enable,
    input  logic [LS_SEL_WIDTH:0]   i_Dm_Load_Store_Type,
    input  logic [XLEN-1:0]         i_Dm_Addr,
    input  logic [XLEN-1:0]         i_Dm_Wdata,
    output logic                    o_Dm_Req_Ready,
    output logic                    o_Dm_Resp_Valid,
    output logic [XLEN-1:0]         o_Dm_Resp_Data,
    output logic                    o_Dm_Resp_Error,
    output logic                    o_Mem_Req_Valid,
    input  logic                    i_Mem_Req_Ready,
    output logic                    o_Mem_Write_Enable,
    output logic [LS_SEL_WIDTH:0]   o_Mem_Load_Store_Type,
    output logic [XLEN-1:0]         o_Mem_Addr,
    output logic [XLEN-1:0]         o_Mem_Wdata,
    input  logic                    i_Mem_Resp_Valid,
    input  logic [XLEN-1:0]         i_Mem_Resp_Data,
    input  logic                    i_Mem_Resp_Error,
    output logic                    o_Busy
);

    arb_state_e            state_q, state_d;
    arb_owner_e            owner_q, owner_d;
    arb_owner_e            select;
    logic                  we_q, we_d;
    logic [LS_SEL_WIDTH:0] type_q, type_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       resp_data_q, resp_data_d;
    logic                  resp_error_q, resp_error_d;

    logic                  idle;
    logic                  grant;
    logic                  req_we;
    logic [LS_SEL_WIDTH:0] req_type;
    logic [XLEN-1:0]       req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic                  if_respond;
    logic                  dm_respond;

    mem_arbiter_fairness #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK),
        .STREAK_WIDTH    (STREAK_WIDTH)
    ) u_fairness (
        .clk      (i_Clock),
        .rst_n    (i_Reset_N),
        .if_valid (i_If_Req_Valid),
        .dm_valid (i_Dm_Req_Valid),
        .grant    (grant),
        .select   (select)
    );

    always_comb begin
        idle  = (state_q == ARB_STATE_IDLE);
        grant = idle && ((select == ARB_OWNER_DM) ? i_Dm_Req_Valid : i_If_Req_Valid);

        // Fetch is always a plain word read regardless of what it might carry.
        if (select == ARB_OWNER_DM) begin
            req_we    = i_Dm_Write_Enable;
            req_type  = i_Dm_Load_Store_Type;
            req_addr  = i_Dm_Addr;
            req_wdata = i_Dm_Wdata;
        end else begin
            req_we    = 1'b0;
            req_type  = LS_TYPE_LOAD_WORD;
            req_addr  = i_If_Addr;
            req_wdata = '0;
        end

        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        type_d       = type_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;

        case (state_q)
            ARB_STATE_IDLE: begin
                if (grant) begin
                    owner_d      = select;
                    we_d         = req_we;
                    type_d       = req_type;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    resp_data_d  = '0;
                    resp_error_d = 1'b0;
                    if (is_misaligned(req_type, req_addr[1:0])) begin
                        resp_error_d = 1'b1;
                        state_d      = ARB_STATE_RESPOND;
                    end else begin
                        state_d      = ARB_STATE_ISSUE;
                    end
                end
            end
            ARB_STATE_ISSUE: begin
                if (i_Mem_Req_Ready) begin
                    state_d = ARB_STATE_WAIT_RESP;
                end
            end
            ARB_STATE_WAIT_RESP: begin
                if (i_Mem_Resp_Valid) begin
                    resp_data_d  = we_q ? '0 : i_Mem_Resp_Data;
                    resp_error_d = i_Mem_Resp_Error;
                    state_d      = ARB_STATE_RESPOND;
                end
            end
            ARB_STATE_RESPOND: begin
                state_d = ARB_STATE_IDLE;
            end
            default: begin
                state_d = ARB_STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_q      <= ARB_STATE_IDLE;
            owner_q      <= ARB_OWNER_IF;
            we_q         <= 1'b0;
            type_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_data_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
        end
    end

    // Ready is held low during reset so every output reads 0 while it is asserted.
    assign o_If_Req_Ready = i_Reset_N && idle && (select == ARB_OWNER_IF);
    assign o_Dm_Req_Ready = i_Reset_N && idle && (select == ARB_OWNER_DM);

    assign if_respond      = (state_q == ARB_STATE_RESPOND) && (owner_q == ARB_OWNER_IF);
    assign dm_respond      = (state_q == ARB_STATE_RESPOND) && (owner_q == ARB_OWNER_DM);
    assign o_If_Resp_Valid = if_respond;
    assign o_If_Resp_Data  = if_respond ? resp_data_q : '0;
    assign o_If_Resp_Error = if_respond && resp_error_q;
    assign o_Dm_Resp_Valid = dm_respond;
    assign o_Dm_Resp_Data  = dm_respond ? resp_data_q : '0;
    assign o_Dm_Resp_Error = dm_respond && resp_error_q;

    assign o_Mem_Req_Valid       = (state_q == ARB_STATE_ISSUE);
    assign o_Mem_Write_Enable    = we_q;
    assign o_Mem_Load_Store_Type = type_q;
    assign o_Mem_Addr            = addr_q;
    assign o_Mem_Wdata           = wdata_q;
    assign o_Busy                = !idle;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the instruction-fetch requester and the load/store (data) requester of the pipelined core.
- One transaction is outstanding at a time.
- Data wins contention by default; a streak counter stops fetch from starving.
- Misaligned requests are rejected locally with an error response and never reach memory.

Parameters:
- XLEN, 32, data and address width.
- MAX_DATA_STREAK, 4, maximum consecutive contended data grants before fetch is forced; 0 = data always wins.
- STREAK_WIDTH, 3, streak counter width; must satisfy 2**STREAK_WIDTH > MAX_DATA_STREAK.

Ports:
- i_Clock  in  1  clock.
- i_Reset_N  in  1  reset, asynchronous, active-low.
- i_If_Req_Valid  in  1  fetch request.
- i_If_Addr  in  XLEN  fetch address.
- o_If_Req_Ready  out  1  fetch request accepted this cycle.
- o_If_Resp_Valid  out  1  fetch response pulse.
- o_If_Resp_Data  out  XLEN  instruction word.
- o_If_Resp_Error  out  1  misaligned or memory error.
- i_Dm_Req_Valid  in  1  data request.
- i_Dm_Write_Enable  in  1  store.
- i_Dm_Load_Store_Type  in  LS_SEL_WIDTH+1  LS_TYPE_* code.
- i_Dm_Addr  in  XLEN  data address.
- i_Dm_Wdata  in  XLEN  store data.
- o_Dm_Req_Ready  out  1  data request accepted this cycle.
- o_Dm_Resp_Valid  out  1  data response pulse.
- o_Dm_Resp_Data  out  XLEN  load data; 0 for stores.
- o_Dm_Resp_Error  out  1  misaligned or memory error.
- o_Mem_Req_Valid  out  1  downstream request.
- i_Mem_Req_Ready  in  1  downstream accept.
- o_Mem_Write_Enable  out  1  downstream write.
- o_Mem_Load_Store_Type  out  LS_SEL_WIDTH+1  downstream access type.
- o_Mem_Addr  out  XLEN  downstream address.
- o_Mem_Wdata  out  XLEN  downstream write data.
- i_Mem_Resp_Valid  in  1  downstream response.
- i_Mem_Resp_Data  in  XLEN  downstream read data.
- i_Mem_Resp_Error  in  1  downstream error.
- o_Busy  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous on i_Reset_N low. State = IDLE, streak = 0, all outputs 0. Reset mid-transaction abandons it; no response is issued.
- States: IDLE, ISSUE, WAIT_RESP, RESPOND.
- IDLE arbitration:
  - Combinational; exactly one of o_If_Req_Ready / o_Dm_Req_Ready is high, only in IDLE.
  - Only data valid -> data. Only fetch valid -> fetch.
  - Both valid -> data, unless MAX_DATA_STREAK != 0 and streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter:
  - Increments (saturating) on a data grant while fetch was also valid.
  - Clears on any fetch grant.
  - Unchanged on an uncontended data grant.
- Accept (ready && valid):
  - Latch owner, address, write enable, type and wdata.
  - Fetch requests are forced to LS_TYPE_LOAD_WORD with write enable 0.
- Alignment:
  - Fault if word access with addr[1:0] != 0, or half access with addr[0] != 0. Byte accesses never fault.
  - Fault -> go to RESPOND with error = 1, data = 0. Nothing is issued downstream.
  - No fault -> go to ISSUE.
- ISSUE: o_Mem_Req_Valid = 1, all o_Mem_* driven from latched registers and stable until i_Mem_Req_Ready. Handshake -> WAIT_RESP.
- WAIT_RESP: on i_Mem_Resp_Valid, capture data and error, then go to RESPOND. Stores return data 0.
- Stray responses: i_Mem_Resp_Valid outside WAIT_RESP is ignored.
- RESPOND:
  - Owner's o_*_Resp_Valid is high for exactly one cycle, with registered data and error.
  - The non-owner's response outputs stay 0.
  - Next state is IDLE.
- Latency:
  - Request accepted at T gives o_Mem_Req_Valid at T+1.
  - Response arriving at N gives o_*_Resp_Valid at N+1; next accept is possible at N+2.
  - Misaligned request accepted at T gives its response at T+1.
- Requester rules: a requester may drop or change valid before ready without penalty. Requests arriving during non-IDLE states wait.

Decomposition:
- Shared package: LS_TYPE_* codes and LS_SEL_WIDTH (existing), plus new ARB_STATE_IDLE/ISSUE/WAIT_RESP/RESPOND encodings, ARB_STATE_WIDTH, and ARB_OWNER_IF/ARB_OWNER_DM.
- Misalignment check: a package function shared with the load/store path.
- Sub-module mem_arbiter_fairness: winner select plus saturating streak counter. Inputs: both valids and the grant strobe. Output: select.

Test Plan:
- Fetch only: addr 0x100, memory ready same cycle, responds 3 cycles later with 0x00500093 -> o_If_Resp_Valid one cycle, data 0x00500093, error 0, o_Mem_Load_Store_Type = LOAD_WORD.
- Contention with MAX_DATA_STREAK = 4, both requesters held valid -> grant order D,D,D,D,F,D,D,D,D,F; streak reads 0 after each F.
- Data LOAD_WORD at 0x102 -> o_Mem_Req_Valid never asserts, o_Dm_Resp_Error = 1 one cycle after accept. LOAD_BYTE at 0x103 -> issued normally.
- Store word 0xDEADBEEF to 0x200 with i_Mem_Req_Ready held low for 5 cycles -> address, data and write enable stable for all 6 valid cycles; o_Dm_Resp_Data = 0.
- i_Mem_Resp_Error = 1 on a data load -> o_Dm_Resp_Error = 1; fetch outputs stay 0.
- i_Reset_N driven low mid WAIT_RESP, then released; later i_Mem_Resp_Valid -> outputs go 0 asynchronously, o_Busy = 0, late response ignored, no response pulse issued.
